// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 active-low matrix keypad one row at a time, debounces both the
// press and the release of a key, and reports each accepted key as a 4-bit hex
// code (row*4 + col). Every accepted code is also shifted into a 32-bit,
// eight-digit entry register that feeds the seven-segment display path, so the
// display shows the last eight keys typed (newest digit in [3:0]).
//
// Parameters
//   SCAN_DIV  clock cycles per row slot (>= 2); the last cycle of a slot is the
//             sample tick, the only cycle in which the columns are read
//   DEBOUNCE  consecutive matching ticks needed to accept a press or a release
//             (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   col_in     in   [3:0] keypad columns, active-low, already synchronised
//   row_out    out  [3:0] row drive, active-low one-hot
//   key_code   out  [3:0] code of the last accepted key
//   key_valid  out  one-cycle pulse when a key is accepted
//   key_down   out  high while the accepted key is held (incl. release debounce)
//   Hexs       out  [31:0] entry register, newest digit in [3:0]
//   clr        in   synchronous clear of Hexs (an accept in the same cycle wins)
// -----------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [31:0] Hexs,
  input  logic        clr
);

  // state    | meaning
  // ---------+-------------------------------------------------------------
  // SCAN     | rotating the active row; waiting for any low column on a tick
  // PRESS_DB | row held; counting ticks where the latched column stays lowest
  // HELD     | key accepted, key_down=1; waiting for the latched column to rise
  // REL_DB   | key_down=1; counting released ticks, a low tick returns to HELD

  generate
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("keypad_scan: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE < 1) begin : g_bad_db
      $error("keypad_scan: DEBOUNCE must be >= 1");
    end
  endgenerate

  localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0] T_LOAD   = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
  localparam bit            DB_ONE   = (DEBOUNCE == 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [1:0]      r;
  logic [1:0]      c;
  logic [CW-1:0]   cnt;

  logic            tick;
  logic            any_low;
  logic [1:0]      low_col;
  logic            same_col;
  logic            col_rel;
  logic [CW-1:0]   cnt_inc;
  logic [1:0]      r_adv;
  logic            accept;
  logic [3:0]      acc_code;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Slot timer runs down from SCAN_DIV-1; the remaining count equals
  // SCAN_DIV-1-t, so the terminal count of zero is the sample tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= T_LOAD;
    end else if (tmr == '0) begin
      tmr <= T_LOAD;
    end else begin
      tmr <= tmr - 1'b1;
    end
  end

  assign tick = (tmr == '0);

  // Lowest-index low column wins; any additional low columns are ignored.
  always_comb begin
    low_col = 2'd3;
    if (!col_in[0]) begin
      low_col = 2'd0;
    end else if (!col_in[1]) begin
      low_col = 2'd1;
    end else if (!col_in[2]) begin
      low_col = 2'd2;
    end
  end

  assign any_low  = (col_in != 4'hF);
  assign same_col = any_low && (low_col == c);
  assign col_rel  = col_in[c];
  assign cnt_inc  = cnt + CNT_ONE;
  assign r_adv    = r + 2'd1;

  // A key is accepted on the DEBOUNCE-th matching tick. With DEBOUNCE==1 that
  // is the detecting tick itself, so the code must come from the live column.
  always_comb begin
    accept   = 1'b0;
    acc_code = {r, c};
    if (tick) begin
      if (state == SCAN && any_low && DB_ONE) begin
        accept   = 1'b1;
        acc_code = {r, low_col};
      end else if (state == PRESS_DB && same_col && cnt_inc == CNT_DONE) begin
        accept   = 1'b1;
        acc_code = {r, c};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      r         <= 2'd0;
      c         <= 2'd0;
      cnt       <= '0;
      row_out   <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      Hexs      <= 32'h0;
    end else begin
      key_valid <= 1'b0;

      if (accept) begin
        key_code  <= acc_code;
        key_valid <= 1'b1;
        key_down  <= 1'b1;
        // The accepted digit survives a simultaneous clear.
        Hexs      <= clr ? {28'h0, acc_code} : {Hexs[27:0], acc_code};
      end else if (clr) begin
        Hexs <= 32'h0;
      end

      if (tick) begin
        case (state)
          SCAN: begin
            if (!any_low) begin
              r       <= r_adv;
              row_out <= row_drive(r_adv);
            end else begin
              c   <= low_col;
              cnt <= CNT_ONE;
              state <= DB_ONE ? HELD : PRESS_DB;
            end
          end

          PRESS_DB: begin
            if (same_col) begin
              if (cnt_inc == CNT_DONE) begin
                state <= HELD;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state   <= SCAN;
              r       <= r_adv;
              row_out <= row_drive(r_adv);
            end
          end

          HELD: begin
            if (col_rel) begin
              cnt <= CNT_ONE;
              if (DB_ONE) begin
                state    <= SCAN;
                key_down <= 1'b0;
                r        <= r_adv;
                row_out  <= row_drive(r_adv);
              end else begin
                state <= REL_DB;
              end
            end
          end

          REL_DB: begin
            if (col_rel) begin
              if (cnt_inc == CNT_DONE) begin
                state    <= SCAN;
                key_down <= 1'b0;
                r        <= r_adv;
                row_out  <= row_drive(r_adv);
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= HELD;
            end
          end

          default: begin
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule
